// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: request/grant/valid arbiter sharing one memory port between fetch and data,
// data first with a fetch anti-starvation override, one access in flight.
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int MEM_LAT = 1,
  parameter int IF_MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [1:0]        d_size,
  input  logic              d_signed,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        mem_size,
  output logic              mem_signed,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
  localparam logic [2:0] LP_LAT = 3'(MEM_LAT);
  localparam logic [3:0] LP_MAXW = 4'(IF_MAX_WAIT);
  state_t     r_state;
  owner_t     r_owner;
  logic [2:0] r_cnt;
  logic [3:0] r_wait;
  logic       w_free, w_resp, w_if_win;
  // Grants are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    w_resp     = ~rst & (r_state == BUSY) & (r_cnt == 3'd1);
    w_free     = ~rst & ((r_state == IDLE) | (r_cnt == 3'd1));
    w_if_win   = if_req & (~d_req | (r_wait >= LP_MAXW));
    if_gnt     = w_free & w_if_win;
    d_gnt      = w_free & d_req & ~w_if_win;
    if_stall   = ~rst & if_req & ~if_gnt;
    d_stall    = ~rst & d_req & ~d_gnt;
    if_valid   = w_resp & (r_owner == OWN_IF);
    d_valid    = w_resp & (r_owner == OWN_D);
    if_rdata   = if_valid ? mem_rdata : 32'h0;
    d_rdata    = d_valid ? mem_rdata : 32'h0;
    mem_en     = if_gnt | d_gnt;
    mem_we     = d_gnt & d_we;
    mem_addr   = d_gnt ? d_addr : if_gnt ? if_addr : '0;
    mem_wdata  = d_gnt ? d_wdata : 32'h0;
    mem_size   = d_gnt ? d_size : if_gnt ? 2'b10 : 2'b00;
    mem_signed = d_gnt & d_signed;
    busy       = (r_state == BUSY);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= OWN_IF;
      r_cnt   <= 3'd0;
      r_wait  <= 4'd0;
    end else begin
      if (if_gnt | d_gnt) begin
        r_state <= BUSY;
        r_owner <= d_gnt ? OWN_D : OWN_IF;
        r_cnt   <= LP_LAT;
      end else if (r_state == BUSY) begin
        r_cnt   <= r_cnt - 3'd1;
        r_state <= (r_cnt == 3'd1) ? IDLE : BUSY;
      end
      r_wait <= (if_gnt | ~if_req) ? 4'd0 : (d_gnt & (r_wait != 4'hf)) ? r_wait + 4'd1 : r_wait;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (latency 1 and 3) checked every cycle against a
// timeline-based model that also plays the role of the memory.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        if_req[2], if_gnt[2], if_valid[2], if_stall[2];
  logic        d_req[2], d_we[2], d_signed[2], d_gnt[2], d_valid[2], d_stall[2];
  logic        mem_en[2], mem_we[2], mem_signed[2], busy[2];
  logic [7:0]  if_addr[2], d_addr[2], mem_addr[2];
  logic [31:0] if_rdata[2], d_wdata[2], d_rdata[2], mem_wdata[2], mem_rdata[2];
  logic [1:0]  d_size[2], mem_size[2];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pend_at[2];
  logic pend_own[2];
  logic [31:0] pend_dat[2];
  int wt[2];
  logic g_if[2], g_d[2];
  logic [7:0] mm[2][256];
  logic fr, ifw, eif, ed, vif, vd, by;
  logic [5:0] sd, si;
  int nv;
  string pre;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    mem_port_arbiter #(.ADDR_W(8), .MEM_LAT(g ? 3 : 1), .IF_MAX_WAIT(3)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]), .if_valid(if_valid[g]),
      .if_rdata(if_rdata[g]), .if_stall(if_stall[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_size(d_size[g]), .d_signed(d_signed[g]), .d_gnt(d_gnt[g]), .d_valid(d_valid[g]),
      .d_rdata(d_rdata[g]), .d_stall(d_stall[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_size(mem_size[g]), .mem_signed(mem_signed[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", n, cyc, a, e);
    end
  endtask

  // Little-endian byte memory; size 00 byte, 01 half, 10 word.
  function automatic logic [31:0] mrd(input int k, input logic [7:0] a, input logic [1:0] s, input logic sg);
    logic [31:0] w;
    w = {mm[k][a + 8'd3], mm[k][a + 8'd2], mm[k][a + 8'd1], mm[k][a]};
    if (s == 2'b00) return sg ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
    if (s == 2'b01) return sg ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
    return w;
  endfunction

  task automatic mwr(input int k, input logic [7:0] a, input logic [1:0] s, input logic [31:0] d);
    int n;
    n = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) mm[k][a + 8'(i)] = d[8*i +: 8];
  endtask

  // Model: an access issued in cycle t answers in cycle t+lat; the port is free when
  // nothing is pending beyond the current cycle.
  always @(negedge clk) begin
    if (cyc == 0)
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 256; i++) mm[k][i] = 8'(i);
        pend_at[k] = -1;
        wt[k] = 0;
      end
    for (int k = 0; k < 2; k++) begin
      pre = k ? "lat3." : "lat1.";
      if (rst) begin
        {fr, ifw, eif, ed, vif, vd, by} = '0;
        pend_at[k] = -1;
        wt[k] = 0;
      end else begin
        fr  = pend_at[k] <= cyc;
        ifw = if_req[k] && (!d_req[k] || wt[k] >= 3);
        eif = fr && ifw;
        ed  = fr && d_req[k] && !ifw;
        vif = pend_at[k] == cyc && !pend_own[k];
        vd  = pend_at[k] == cyc && pend_own[k];
        by  = pend_at[k] >= cyc;
      end
      chk({pre, "if_gnt"}, 32'(if_gnt[k]), 32'(eif));
      chk({pre, "d_gnt"}, 32'(d_gnt[k]), 32'(ed));
      chk({pre, "if_stall"}, 32'(if_stall[k]), 32'(!rst && if_req[k] && !eif));
      chk({pre, "d_stall"}, 32'(d_stall[k]), 32'(!rst && d_req[k] && !ed));
      chk({pre, "if_valid"}, 32'(if_valid[k]), 32'(vif));
      chk({pre, "d_valid"}, 32'(d_valid[k]), 32'(vd));
      chk({pre, "if_rdata"}, if_rdata[k], vif ? mem_rdata[k] : 32'h0);
      chk({pre, "d_rdata"}, d_rdata[k], vd ? mem_rdata[k] : 32'h0);
      chk({pre, "mem_en"}, 32'(mem_en[k]), 32'(eif || ed));
      chk({pre, "mem_we"}, 32'(mem_we[k]), 32'(ed && d_we[k]));
      chk({pre, "mem_addr"}, 32'(mem_addr[k]), ed ? 32'(d_addr[k]) : eif ? 32'(if_addr[k]) : 32'h0);
      chk({pre, "mem_wdata"}, mem_wdata[k], ed ? d_wdata[k] : 32'h0);
      chk({pre, "mem_size"}, 32'(mem_size[k]), ed ? 32'(d_size[k]) : eif ? 32'd2 : 32'h0);
      chk({pre, "mem_signed"}, 32'(mem_signed[k]), 32'(ed && d_signed[k]));
      chk({pre, "busy"}, 32'(busy[k]), 32'(by));
      if (!rst) begin
        if (pend_at[k] == cyc) pend_at[k] = -1;
        if (eif || ed) begin
          pend_at[k] = cyc + (k ? 3 : 1);
          pend_own[k] = ed;
          if (ed && d_we[k]) begin
            mwr(k, d_addr[k], d_size[k], d_wdata[k]);
            pend_dat[k] = $urandom;
          end else
            pend_dat[k] = ed ? mrd(k, d_addr[k], d_size[k], d_signed[k]) : mrd(k, if_addr[k], 2'b10, 1'b0);
        end
        if (eif || !if_req[k]) wt[k] = 0;
        else if (ed && wt[k] < 15) wt[k] = wt[k] + 1;
      end
      g_if[k] = eif;
      g_d[k] = ed;
      mem_rdata[k] = (pend_at[k] == cyc + 1) ? pend_dat[k] : $urandom;
    end
    cyc++;
  end

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input int k, input logic r, input logic we, input logic [7:0] a,
                      input logic [31:0] wd, input logic [1:0] s, input logic sg);
    d_req[k] = r; d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd; d_size[k] = s; d_signed[k] = sg;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 0; if_addr[k] = 0;
      setd(k, 0, 0, 0, 0, 0, 0);
    end
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(busy[1]), 0);
    chk("rst.mem_en", 32'(mem_en[0]), 0);
    nx(); rst = 0;
    // fetch stream, latency 1
    nx(); if_req[0] = 1; if_addr[0] = 8'h00; @(negedge clk);
    chk("fo.gnt0", 32'(if_gnt[0]), 1);
    nx(); if_addr[0] = 8'h04; @(negedge clk);
    chk("fo.gnt1", 32'(if_gnt[0]), 1);
    chk("fo.rdata0", if_rdata[0], 32'h03020100);
    nx(); if_addr[0] = 8'h08; @(negedge clk);
    chk("fo.rdata1", if_rdata[0], 32'h07060504);
    nx(); if_req[0] = 0; @(negedge clk);
    chk("fo.valid2", 32'(if_valid[0]), 1);
    chk("fo.rdata2", if_rdata[0], 32'h0b0a0908);
    // conflict
    nx(); if_req[0] = 1; if_addr[0] = 8'h0c; setd(0, 1, 0, 8'h40, 0, 2'b10, 0); @(negedge clk);
    chk("cf.d_gnt", 32'(d_gnt[0]), 1);
    chk("cf.if_gnt", 32'(if_gnt[0]), 0);
    chk("cf.if_stall", 32'(if_stall[0]), 1);
    nx(); d_req[0] = 0; @(negedge clk);
    chk("cf.d_valid", 32'(d_valid[0]), 1);
    chk("cf.d_rdata", d_rdata[0], 32'h43424140);
    chk("cf.if_gnt2", 32'(if_gnt[0]), 1);
    nx(); if_req[0] = 0;
    // starvation: three data wins, forced fetch, data again
    nx(); if_req[0] = 1; if_addr[0] = 8'h10; setd(0, 1, 0, 8'h20, 0, 2'b10, 0);
    sd = 0; si = 0;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) nx();
      @(negedge clk);
      sd = {sd[4:0], d_gnt[0]};
      si = {si[4:0], if_gnt[0]};
    end
    chk("starve.d", 32'(sd), 32'(6'b111011));
    chk("starve.if", 32'(si), 32'(6'b000100));
    nx(); if_req[0] = 0; d_req[0] = 0;
    // latency 3: byte store then byte loads
    nx(); setd(1, 1, 1, 8'h10, 32'h000000a5, 2'b00, 0); @(negedge clk);
    chk("lat.gnt", 32'(d_gnt[1]), 1);
    chk("lat.we", 32'(mem_we[1]), 1);
    chk("lat.busy0", 32'(busy[1]), 0);
    nx(); setd(1, 1, 0, 8'h10, 0, 2'b00, 0); @(negedge clk);
    chk("lat.we1", 32'(mem_we[1]), 0);
    chk("lat.stall1", 32'(d_stall[1]), 1);
    chk("lat.busy1", 32'(busy[1]), 1);
    nx(); @(negedge clk);
    chk("lat.busy2", 32'(busy[1]), 1);
    chk("lat.valid2", 32'(d_valid[1]), 0);
    nx(); @(negedge clk);
    chk("lat.valid3", 32'(d_valid[1]), 1);
    chk("lat.gnt3", 32'(d_gnt[1]), 1);
    chk("lat.busy3", 32'(busy[1]), 1);
    nx(); d_signed[1] = 1; @(negedge clk);
    chk("lat.stall4", 32'(d_stall[1]), 1);
    nx(); nx(); @(negedge clk);
    chk("lat.valid6", 32'(d_valid[1]), 1);
    chk("lat.ldu", d_rdata[1], 32'h000000a5);
    chk("lat.gnt6", 32'(d_gnt[1]), 1);
    nx(); d_req[1] = 0; nx(); nx(); @(negedge clk);
    chk("lat.lds", d_rdata[1], 32'hffffffa5);
    nx(); @(negedge clk);
    chk("lat.idle", 32'(busy[1]), 0);
    // reset in the middle of an access
    nx(); setd(1, 1, 0, 8'h40, 0, 2'b10, 0); @(negedge clk);
    chk("rs.gnt", 32'(d_gnt[1]), 1);
    nx(); d_req[1] = 0; if_req[1] = 1; if_addr[1] = 8'h30;
    nx(); rst = 1; #1;
    chk("rs.busy", 32'(busy[1]), 0);
    chk("rs.if_stall", 32'(if_stall[1]), 0);
    chk("rs.if_gnt", 32'(if_gnt[1]), 0);
    chk("rs.mem_en", 32'(mem_en[1]), 0);
    nx(); rst = 0; @(negedge clk);
    chk("rs.no_valid", 32'(d_valid[1]), 0);
    chk("rs.first_gnt", 32'(if_gnt[1]), 1);
    nx(); if_req[1] = 0;
    repeat (3) nx();
    // fetch flushed while stalled, then flushed after grant
    nx(); setd(1, 1, 0, 8'h44, 0, 2'b10, 0); if_req[1] = 1; if_addr[1] = 8'h20; @(negedge clk);
    chk("fl.d_gnt", 32'(d_gnt[1]), 1);
    chk("fl.if_gnt", 32'(if_gnt[1]), 0);
    nx(); d_req[1] = 0;
    nx(); if_req[1] = 0;
    nv = 0;
    repeat (5) begin
      nx(); @(negedge clk);
      nv += int'(if_valid[1] | if_gnt[1]);
    end
    chk("fl.none", 32'(nv), 0);
    nx(); if_req[1] = 1; if_addr[1] = 8'h24; @(negedge clk);
    chk("fl.gnt", 32'(if_gnt[1]), 1);
    nx(); if_req[1] = 0; nx(); nx(); @(negedge clk);
    chk("fl.valid", 32'(if_valid[1]), 1);
    chk("fl.rdata", if_rdata[1], 32'h27262524);
    // random traffic on both instances, with occasional resets
    for (int c = 0; c < 3000; c++) begin
      nx();
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        if (!if_req[k] || g_if[k]) begin
          if_req[k] = ($urandom_range(0, 2) != 0);
          if_addr[k] = 8'($urandom);
        end else if ($urandom_range(0, 9) == 0) if_req[k] = 0;
        if (!d_req[k] || g_d[k])
          setd(k, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom), $urandom,
               2'($urandom_range(0, 2)), $urandom_range(0, 1) == 1);
        else if ($urandom_range(0, 9) == 0) d_req[k] = 0;
      end
    end
    nx(); rst = 0;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 0;
      d_req[k] = 0;
    end
    repeat (5) nx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
